// File: rtl/uart16550_tx_sched_if.sv
// rtl/uart16550_tx_sched_if.sv - requester streams and uart register port of the TX scheduler
interface uart16550_tx_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [2:0]        u_a;
    logic [31:0]       u_d;
    logic              u_rd;
    logic              u_we;
    logic [31:0]       u_spo;
    logic              init_done;
    logic [NREQ-1:0]   grant;

    modport master (
        input  req_valid, req_data, req_last, u_spo,
        output req_ready, u_a, u_d, u_rd, u_we, init_done, grant
    );

    modport slave (
        output req_valid, req_data, req_last, u_spo,
        input  req_ready, u_a, u_d, u_rd, u_we, init_done, grant
    );
endinterface

// File: rtl/uart16550_tx_sched.sv
// rtl/uart16550_tx_sched.sv - boot configurator and round-robin THR scheduler for a uart16550
module uart16550_tx_sched #(
    parameter int          NREQ       = 4,
    parameter logic [15:0] BAUD_DIV   = 16'd407,
    parameter logic [7:0]  LCR_VAL    = 8'h03,
    parameter logic [7:0]  FCR_VAL    = 8'h01,
    parameter logic [7:0]  IER_VAL    = 8'h00,
    parameter int          FIFO_BURST = 16,
    parameter bit          LENDIAN    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    uart16550_tx_sched_if.master bus
);
    localparam int CW = $clog2(FIFO_BURST + 1);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [3:0] {
        I_LCRD, I_DLL, I_DLM, I_LCR, I_FCR0, I_FCR1, I_IER,
        ARB, POLL, SEND, GAP1, GAP2
    } state_t;

    state_t          state, state_nx;
    logic [NREQ-1:0] grant_q, grant_nx;
    logic [PW-1:0]   rr_ptr, rr_nx;
    logic [CW-1:0]   credit, credit_nx;
    logic            init_done_q, init_nx;

    logic [PW-1:0]   g_idx, hit_idx, s_idx;
    logic            hit, sel_valid, sel_last;
    logic [7:0]      sel_byte;

    logic [2:0]      a_c;
    logic [7:0]      byte_c;
    logic            rd_c, we_c;
    logic [NREQ-1:0] rdy_c;

    always_comb begin
        g_idx     = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_byte  = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                g_idx     = PW'(i);
                sel_valid = bus.req_valid[i];
                sel_last  = bus.req_last[i];
                sel_byte  = bus.req_data[8*i +: 8];
            end
        end
    end

    // Walk downward so the requester closest to rr_ptr is the one that sticks.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        s_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            s_idx = PW'((int'(rr_ptr) + k) % NREQ);
            if (bus.req_valid[s_idx]) begin
                hit     = 1'b1;
                hit_idx = s_idx;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        grant_nx  = grant_q;
        rr_nx     = rr_ptr;
        credit_nx = credit;
        init_nx   = init_done_q;
        a_c       = 3'd0;
        byte_c    = 8'h00;
        rd_c      = 1'b0;
        we_c      = 1'b0;
        rdy_c     = '0;
        case (state)
            I_LCRD: begin a_c = 3'd3; byte_c = 8'h80;           we_c = 1'b1; state_nx = I_DLL;  end
            I_DLL:  begin a_c = 3'd0; byte_c = BAUD_DIV[7:0];   we_c = 1'b1; state_nx = I_DLM;  end
            I_DLM:  begin a_c = 3'd1; byte_c = BAUD_DIV[15:8];  we_c = 1'b1; state_nx = I_LCR;  end
            I_LCR:  begin a_c = 3'd3; byte_c = LCR_VAL & 8'h7F; we_c = 1'b1; state_nx = I_FCR0; end
            // FIFO reset bits are level-held in the uart, so pulse them and clear them again.
            I_FCR0: begin a_c = 3'd2; byte_c = FCR_VAL | 8'h06; we_c = 1'b1; state_nx = I_FCR1; end
            I_FCR1: begin a_c = 3'd2; byte_c = FCR_VAL & 8'hF9; we_c = 1'b1; state_nx = I_IER;  end
            I_IER: begin
                a_c      = 3'd1;
                byte_c   = IER_VAL;
                we_c     = 1'b1;
                init_nx  = 1'b1;
                state_nx = ARB;
            end
            ARB: begin
                if (|grant_q) begin
                    state_nx = POLL;
                end else if (hit) begin
                    grant_nx          = '0;
                    grant_nx[hit_idx] = 1'b1;
                    state_nx          = POLL;
                end
            end
            POLL: begin
                a_c  = 3'd5;
                rd_c = 1'b1;
                if (bus.u_spo[29]) begin
                    credit_nx = CW'(FIFO_BURST);
                    state_nx  = SEND;
                end else begin
                    state_nx = GAP1;
                end
            end
            SEND: begin
                if (sel_valid && credit != '0) begin
                    we_c         = 1'b1;
                    byte_c       = sel_byte;
                    rdy_c[g_idx] = 1'b1;
                    credit_nx    = credit - CW'(1);
                    if (sel_last) begin
                        grant_nx = '0;
                        rr_nx    = (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + PW'(1);
                        state_nx = GAP1;
                    end else if (credit == CW'(1)) begin
                        state_nx = GAP1;
                    end
                end
            end
            // THRE lags a THR write by two cycles; polling sooner would see stale status.
            GAP1:    state_nx = GAP2;
            GAP2:    state_nx = ARB;
            default: state_nx = I_LCRD;
        endcase
        if (rst) begin
            a_c    = 3'd0;
            byte_c = 8'h00;
            rd_c   = 1'b0;
            we_c   = 1'b0;
            rdy_c  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= I_LCRD;
            grant_q     <= '0;
            rr_ptr      <= '0;
            credit      <= '0;
            init_done_q <= 1'b0;
        end else begin
            state       <= state_nx;
            grant_q     <= grant_nx;
            rr_ptr      <= rr_nx;
            credit      <= credit_nx;
            init_done_q <= init_nx;
        end
    end

    assign bus.u_a       = a_c;
    assign bus.u_d       = LENDIAN ? {24'h000000, byte_c} : {byte_c, 24'h000000};
    assign bus.u_rd      = rd_c;
    assign bus.u_we      = we_c;
    assign bus.req_ready = rdy_c;
    assign bus.grant     = grant_q;
    assign bus.init_done = init_done_q;
endmodule
